// File: rtl/coin_acceptor.sv
// coin_acceptor -- vending machine coin front end.
//   Synchronises and debounces the 5 Rs and 10 Rs sensors, turns each debounced
//   rising edge into a coin event, queues accepted coins in a small FIFO and
//   replays them to the vending FSM as single-cycle codes separated by idle gaps.
//
// Ports:
//   clk, rst         clock; asynchronous active-high reset
//   coin5_raw        raw 5 Rs sensor (asynchronous)
//   coin10_raw       raw 10 Rs sensor (asynchronous)
//   accept_en        1 = accept new coins, 0 = reject every new event
//   coin_code        registered code to vending FSM: 00 none, 01 5 Rs, 10 10 Rs
//   coin_reject      one-cycle pulse per rejected event (return-chute flap)
//   fifo_count       coins queued and not yet emitted
//   busy             FIFO non-empty or output FSM not idle
//   cnt5/cnt10/cnt_rej  saturating 8-bit statistics, present only when the
//                    macro COIN_ACCEPTOR_STATS_EN is defined

// Per-sensor conditioning: 2-flop synchroniser, debounce, rising-edge detect.
module coin_debounce #(
  parameter int DEB_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic rise
);
  localparam int CW = $clog2(DEB_CYCLES + 1);

  logic          s1, s2, stable;
  logic [CW-1:0] cnt;
  logic          settle;

  // The counter is about to reach DEB_CYCLES: stable takes s2 at this edge.
  assign settle = (s2 != stable) && (cnt == CW'(DEB_CYCLES - 1));
  // The event is reported in the same cycle the stable flop is loaded with 1.
  assign rise   = settle && s2;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1     <= 1'b0;
      s2     <= 1'b0;
      stable <= 1'b0;
      cnt    <= '0;
    end else begin
      s1 <= raw;
      s2 <= s1;
      if (s2 == stable) begin
        cnt <= '0;
      end else if (settle) begin
        stable <= s2;
        cnt    <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end
endmodule

module coin_acceptor #(
  parameter int DEB_CYCLES = 4,
  parameter int GAP        = 2,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          coin5_raw,
  input  logic                          coin10_raw,
  input  logic                          accept_en,
  output logic [1:0]                    coin_code,
  output logic                          coin_reject,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          busy
`ifdef COIN_ACCEPTOR_STATS_EN
  ,
  output logic [7:0]                    cnt5,
  output logic [7:0]                    cnt10,
  output logic [7:0]                    cnt_rej
`endif
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int GW = (GAP > 1) ? $clog2(GAP + 1) : 1;

  typedef enum logic [1:0] {IDLE, EMIT, GAPS} state_t;

  // lane 0 = 5 Rs, lane 1 = 10 Rs
  logic [1:0] raw, rise;
  assign raw = {coin10_raw, coin5_raw};

  for (genvar i = 0; i < 2; i++) begin : g_sense
    coin_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb (
      .clk  (clk),
      .rst  (rst),
      .raw  (raw[i]),
      .rise (rise[i])
    );
  end

  // ---------------- event resolution ----------------
  logic       full, one_evt, push, pop, rej;
  logic [1:0] push_code;

  // Full is taken from the registered count, i.e. before any same-cycle pop.
  assign full      = (fifo_count == CW'(FIFO_DEPTH));
  assign one_evt   = rise[0] ^ rise[1];
  assign push      = one_evt && accept_en && !full;
  assign rej       = (&rise) || (one_evt && (!accept_en || full));
  assign push_code = rise[1] ? 2'b10 : 2'b01;

  // ---------------- FIFO ----------------
  logic [1:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_code;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + CW'(1);
        2'b01:   fifo_count <= fifo_count - CW'(1);
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  // ---------------- output FSM ----------------
  state_t        state, state_n;
  logic [1:0]    code_n;
  logic [GW-1:0] gap_cnt, gap_n;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      coin_code   <= 2'b00;
      gap_cnt     <= '0;
      coin_reject <= 1'b0;
    end else begin
      state       <= state_n;
      coin_code   <= code_n;
      gap_cnt     <= gap_n;
      coin_reject <= rej;
    end
  end

  always_comb begin
    state_n = state;
    code_n  = coin_code;
    gap_n   = gap_cnt;
    pop     = 1'b0;
    case (state)
      IDLE: begin
        code_n = 2'b00;
        if (fifo_count != '0) begin
          pop     = 1'b1;
          code_n  = mem[rd_ptr];
          state_n = EMIT;
        end
      end
      EMIT: begin
        code_n  = 2'b00;
        gap_n   = GW'(GAP - 1);
        state_n = GAPS;
      end
      GAPS: begin
        // Leave when the decrement lands on 0, so IDLE is the last idle
        // cycle and back-to-back codes see exactly GAP cycles of 00.
        code_n = 2'b00;
        if (gap_cnt <= GW'(1)) state_n = IDLE;
        else                   gap_n   = gap_cnt - GW'(1);
      end
      default: begin
        code_n  = 2'b00;
        state_n = IDLE;
      end
    endcase
  end

  assign busy = (fifo_count != '0) || (state != IDLE);

`ifdef COIN_ACCEPTOR_STATS_EN
  // ---------------- statistics ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt5    <= '0;
      cnt10   <= '0;
      cnt_rej <= '0;
    end else begin
      if (push && rise[0] && cnt5  != 8'hff) cnt5    <= cnt5  + 8'd1;
      if (push && rise[1] && cnt10 != 8'hff) cnt10   <= cnt10 + 8'd1;
      if (rej && cnt_rej != 8'hff)           cnt_rej <= cnt_rej + 8'd1;
    end
  end
`endif
endmodule
